// File: rtl/uart_tx_arbiter_if.sv
// Request/transmit bundle between the message sources, the TX arbiter and
// the UART TX FIFO write side.
interface uart_tx_arbiter_if #(
    parameter int NUM_REQ   = 4,
    parameter int DATA_BITS = 8
);
    // A byte of requester i moves when ReqValid[i] and ReqReady[i] are both
    // high at a SysClk edge; TxWrite is that same event seen from the FIFO.
    logic [NUM_REQ-1:0]           ReqValid;
    logic [NUM_REQ*DATA_BITS-1:0] ReqData;
    logic [NUM_REQ-1:0]           ReqLast;
    logic [NUM_REQ-1:0]           ReqReady;
    logic [DATA_BITS-1:0]         TxData;
    logic                         TxWrite;
    logic                         TxFull;
    logic [NUM_REQ-1:0]           Grant;
    logic                         Busy;
    logic                         BurstCut;

    modport master (
        output ReqValid, ReqData, ReqLast, TxFull,
        input  ReqReady, TxData, TxWrite, Grant, Busy, BurstCut
    );

    modport slave (
        input  ReqValid, ReqData, ReqLast, TxFull,
        output ReqReady, TxData, TxWrite, Grant, Busy, BurstCut
    );
endinterface

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing the UART TX FIFO write port among NUM_REQ
// message sources; a grant lasts one message or at most MAX_BURST bytes.
module uart_tx_arbiter #(
    parameter int NUM_REQ   = 4,
    parameter int DATA_BITS = 8,
    parameter int MAX_BURST = 16
) (
    input  logic SysClk,
    input  logic Rst,
    uart_tx_arbiter_if.slave bus
);
    localparam int IDX_W = $clog2(NUM_REQ);
    localparam int CNT_W = $clog2(MAX_BURST + 1);

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    state_t             state_q, state_d;
    logic [NUM_REQ-1:0] grant_q, grant_d;
    logic [IDX_W-1:0]   owner_q, owner_d;
    logic [IDX_W-1:0]   last_owner_q, last_owner_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               burst_cut_q, burst_cut_d;

    logic               pick_found;
    logic [IDX_W-1:0]   pick_idx;
    logic               owner_valid;
    logic               owner_last;
    logic [DATA_BITS-1:0] owner_data;
    logic               xfer;
    logic               at_limit;

    always_ff @(posedge SysClk) begin
        if (!Rst) begin
            state_q      <= IDLE;
            grant_q      <= '0;
            owner_q      <= '0;
            last_owner_q <= IDX_W'(NUM_REQ - 1);
            cnt_q        <= '0;
            burst_cut_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            grant_q      <= grant_d;
            owner_q      <= owner_d;
            last_owner_q <= last_owner_d;
            cnt_q        <= cnt_d;
            burst_cut_q  <= burst_cut_d;
        end
    end

    // Search starts just after the previous owner so every source gets a turn.
    always_comb begin
        int cand;
        pick_found = 1'b0;
        pick_idx   = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            cand = (int'(last_owner_q) + k) % NUM_REQ;
            if (!pick_found && bus.ReqValid[IDX_W'(cand)]) begin
                pick_found = 1'b1;
                pick_idx   = IDX_W'(cand);
            end
        end
    end

    always_comb begin
        owner_valid = bus.ReqValid[owner_q];
        owner_last  = bus.ReqLast[owner_q];
        owner_data  = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (owner_q == IDX_W'(i)) begin
                owner_data = bus.ReqData[i*DATA_BITS +: DATA_BITS];
            end
        end
    end

    assign xfer     = (state_q == GRANT) && owner_valid && !bus.TxFull;
    assign at_limit = (cnt_q == CNT_W'(MAX_BURST - 1));

    always_comb begin
        state_d      = state_q;
        grant_d      = grant_q;
        owner_d      = owner_q;
        last_owner_d = last_owner_q;
        cnt_d        = cnt_q;
        burst_cut_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (pick_found) begin
                    state_d           = GRANT;
                    owner_d           = pick_idx;
                    grant_d           = '0;
                    grant_d[pick_idx] = 1'b1;
                    cnt_d             = '0;
                end
            end
            GRANT: begin
                if (xfer) begin
                    // A message end on the last allowed byte is an ordinary release.
                    if (owner_last || at_limit) begin
                        state_d      = IDLE;
                        grant_d      = '0;
                        last_owner_d = owner_q;
                        cnt_d        = '0;
                        burst_cut_d  = !owner_last;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end
            default: begin
                state_d = IDLE;
                grant_d = '0;
            end
        endcase
    end

    always_comb begin
        bus.ReqReady = '0;
        bus.TxWrite  = 1'b0;
        bus.TxData   = '0;
        if (Rst && (state_q == GRANT)) begin
            bus.ReqReady[owner_q] = owner_valid && !bus.TxFull;
            bus.TxWrite           = owner_valid && !bus.TxFull;
            bus.TxData            = owner_data;
        end
        bus.Grant    = grant_q;
        bus.Busy     = (state_q == GRANT);
        bus.BurstCut = burst_cut_q;
    end
endmodule
